// File: rtl/mem_exc_unit.sv
// Memory-stage exception arbiter: prioritises per-instruction exception flags and
// the pending interrupt, drives CP0, flushes the pipeline and redirects fetch.
module mem_exc_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_is_branch,
    input  logic        m_if_adel,
    input  logic        m_ri,
    input  logic        m_ov,
    input  logic        m_syscall,
    input  logic        m_break,
    input  logic        m_eret,
    input  logic        m_ls_adel,
    input  logic        m_ls_ades,
    input  logic [31:0] m_ls_addr,
    input  logic        interrupt,
    input  logic [31:0] cp0_epc,
    input  logic        redirect_ready,
    output logic        exception,
    output logic [5:0]  m_excCode,
    output logic        isBadAddr,
    output logic [31:0] invalid_addr,
    output logic [31:0] excPC,
    output logic        inDelaySlot,
    output logic        ERET2pc,
    output logic        flush,
    output logic        m_commit,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        prev_branch_q, prev_branch_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        take;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        exception    = 1'b0;
        m_excCode    = 6'h00;
        isBadAddr    = 1'b0;
        invalid_addr = 32'h0;
        excPC        = 32'h0;
        inDelaySlot  = 1'b0;
        take         = resetn && (state_q == IDLE) && m_valid;

        if (take) begin
            exception   = 1'b1;
            excPC       = m_pc;
            inDelaySlot = prev_branch_q;
            if (interrupt) begin
                m_excCode = 6'h00;
            end else if (m_if_adel) begin
                m_excCode    = 6'h04;
                isBadAddr    = 1'b1;
                invalid_addr = m_pc;
            end else if (m_ri) begin
                m_excCode = 6'h0A;
            end else if (m_ov) begin
                m_excCode = 6'h0C;
            end else if (m_syscall) begin
                m_excCode = 6'h08;
            end else if (m_break) begin
                m_excCode = 6'h09;
            end else if (m_ls_adel) begin
                m_excCode    = 6'h04;
                isBadAddr    = 1'b1;
                invalid_addr = m_ls_addr;
            end else if (m_ls_ades) begin
                m_excCode    = 6'h05;
                isBadAddr    = 1'b1;
                invalid_addr = m_ls_addr;
            end else begin
                exception = 1'b0;
            end
        end
    end

    // An exception always wins over a simultaneous ERET.
    assign ERET2pc        = take & m_eret & ~exception;
    assign flush          = exception | ERET2pc;
    assign m_commit       = take & ~flush;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    always_comb begin
        state_d          = state_q;
        prev_branch_d    = prev_branch_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d          = REDIR;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = exception ? EXC_VECTOR : cp0_epc;
                    prev_branch_d    = 1'b0;
                end else if (m_commit) begin
                    prev_branch_d = m_is_branch;
                end
            end
            REDIR: begin
                if (redirect_ready) begin
                    state_d          = IDLE;
                    redirect_valid_d = 1'b0;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= IDLE;
            prev_branch_q    <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
        end else begin
            state_q          <= state_d;
            prev_branch_q    <= prev_branch_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

endmodule

// File: doc/mem_exc_unit.md
Name: mem_exc_unit

Overview:
- Memory-stage exception arbiter that sits directly upstream of the coprocessor-0 register block.
- Collects per-instruction exception flags carried down the pipeline and prioritises them together with the pending interrupt, then drives the CP0 exception/ERET inputs (code, bad address, EPC source, delay-slot flag).
- Flushes the pipeline and delivers the redirect PC (exception vector or EPC) to fetch through a valid/ready handshake.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for all exceptions and interrupts.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- m_valid  in  1  instruction present in MEM this cycle
- m_pc  in  32  PC of MEM instruction
- m_is_branch  in  1  MEM instruction is a branch/jump (next instruction is its delay slot)
- m_if_adel  in  1  fetch address misaligned
- m_ri  in  1  reserved instruction
- m_ov  in  1  arithmetic overflow
- m_syscall  in  1  SYSCALL
- m_break  in  1  BREAK
- m_eret  in  1  ERET
- m_ls_adel  in  1  misaligned load
- m_ls_ades  in  1  misaligned store
- m_ls_addr  in  32  load/store effective address
- interrupt  in  1  pending enabled interrupt from CP0
- cp0_epc  in  32  current EPC from CP0
- redirect_ready  in  1  fetch accepts redirect
- exception  out  1  to CP0: take exception this cycle
- m_excCode  out  6  to CP0: ExcCode, bit 5 always 0
- isBadAddr  out  1  to CP0: load BadVAddr
- invalid_addr  out  32  to CP0: BadVAddr value
- excPC  out  32  to CP0: faulting PC (CP0 subtracts 4 for delay slot)
- inDelaySlot  out  1  to CP0: MEM instruction is in a delay slot
- ERET2pc  out  1  to CP0: ERET retiring
- flush  out  1  kill IF/ID/EX contents this cycle
- m_commit  out  1  MEM instruction may write memory/registers
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, prev_branch=0, redirect_valid=0, redirect_pc=0. All combinational outputs are forced to 0 while resetn is low.
- FSM states:
  - IDLE: normal operation.
  - REDIR: waiting for fetch to accept the redirect.
- take = resetn & state==IDLE & m_valid. All CP0-facing outputs, flush and m_commit are combinational and are 0 unless take.
- Priority, highest first:
  - interrupt: code 0x00, isBadAddr=0
  - m_if_adel: 0x04, invalid_addr=m_pc
  - m_ri: 0x0A
  - m_ov: 0x0C
  - m_syscall: 0x08
  - m_break: 0x09
  - m_ls_adel: 0x04, invalid_addr=m_ls_addr
  - m_ls_ades: 0x05, invalid_addr=m_ls_addr
- isBadAddr=1 only for the three AdE cases; invalid_addr=0 otherwise.
- exception = take & any of the above. excPC=m_pc when take, else 0.
- ERET2pc = take & m_eret & ~exception. An exception always overrides a simultaneous ERET.
- inDelaySlot = take & prev_branch.
- prev_branch register:
  - On take & ~exception & ~ERET2pc, loads m_is_branch.
  - Cleared whenever flush=1.
  - Otherwise holds; bubbles (m_valid=0) do not clear it.
- m_commit = take & ~exception & ~ERET2pc. A faulting or ERET instruction never writes back or stores.
- flush = exception | ERET2pc (single-cycle pulse).
- On flush, next edge:
  - state←REDIR, redirect_valid←1.
  - redirect_pc←EXC_VECTOR for an exception, or cp0_epc sampled in the flush cycle for ERET.
- REDIR:
  - redirect_valid=1 and redirect_pc held stable until redirect_ready=1.
  - On the edge with redirect_ready=1: redirect_valid←0, state←IDLE.
  - All m_valid inputs are ignored: no exception, no commit, no flush.
  - Interrupts stay pending in CP0 and are taken on the first valid instruction back in IDLE.
- Interrupt with m_valid=0 is not taken (needs an instruction to attach EPC to).
- Minimum turnaround: flush at cycle N, redirect_valid high at N+1, earliest IDLE at N+2.
- Reset asserted in REDIR: abandons the redirect; redirect_valid drops immediately.

Test Plan:
- m_valid=1, m_pc=32'h8000_0010, m_ov=1 → exception=1, m_excCode=0x0C, isBadAddr=0, flush=1, m_commit=0. Next cycle redirect_valid=1, redirect_pc=32'hBFC0_0380.
- Branch at 32'h8000_0100 commits; delay slot at 32'h8000_0104 with m_ls_ades=1, m_ls_addr=32'h1000_0003 → inDelaySlot=1, m_excCode=0x05, isBadAddr=1, invalid_addr=32'h1000_0003, excPC=32'h8000_0104.
- m_eret=1 with cp0_epc=32'h8000_0200; redirect_ready held 0 for 3 cycles → ERET2pc one-cycle pulse; redirect_valid=1 and redirect_pc=32'h8000_0200 stable for 4 cycles; IDLE after ready.
- m_eret=1 and m_ri=1 together → exception=1, code 0x0A, ERET2pc=0, redirect_pc=EXC_VECTOR.
- interrupt=1 with m_valid=0 for 2 cycles, then m_valid=1, m_syscall=1 → no action during bubbles; then code 0x00 (interrupt beats syscall), excPC=m_pc.
- Assert resetn=0 during REDIR → redirect_valid=0 immediately. After release: IDLE, prev_branch=0, and a clean instruction gives m_commit=1.
